sdram_burst_sched: RTL and testbench

- Schedules burst write and burst read transactions into the SDRAM controller's write and read ports.
- Treats a fixed SDRAM address window as a ring buffer of bursts.
  - Writes fire when the upstream write FIFO holds a full burst.
  - Reads fire when the downstream read FIFO has room for one.
- Round-robin arbitration between write and read.
- Sits between the user FIFOs and the controller; data words bypass this block.

---
 rtl/sdram_burst_sched.sv | 206 ++++++++++++++++++++
 tb/tb_sdram_burst_sched.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_sched.sv
// Burst scheduler: treats an SDRAM window as a ring of bursts and
// round-robins whole-burst writes and reads into the controller ports.
module sdram_burst_sched #(
  parameter int unsigned BURST_LEN  = 256,
  parameter logic [23:0] BASE_ADDR  = 24'h000000,
  parameter logic [23:0] END_ADDR   = 24'h001000,
  parameter int unsigned FIFO_DEPTH = 1024
) (
  input  logic        i_sysclk,
  input  logic        i_sysrst,
  input  logic        i_init_done,
  input  logic        i_clear,
  input  logic        i_rd_enable,
  input  logic [10:0] i_wr_fifo_cnt,
  input  logic [10:0] i_rd_fifo_cnt,
  output logic        o_wr_req,
  output logic [23:0] o_wr_addr,
  output logic [9:0]  o_wr_burst_len,
  input  logic        i_wr_ack,
  output logic        o_rd_req,
  output logic [23:0] o_rd_addr,
  output logic [9:0]  o_rd_burst_len,
  input  logic        i_rd_ack,
  output logic [15:0] o_fill,
  output logic        o_full,
  output logic        o_empty,
  output logic        o_err
);

  localparam int unsigned RING_BURSTS =
    (END_ADDR - BASE_ADDR) / BURST_LEN;
  localparam logic [15:0] RING_B = 16'(RING_BURSTS);
  localparam logic [23:0] BL24   = 24'(BURST_LEN);
  localparam logic [15:0] BL16   = 16'(BURST_LEN);
  localparam logic [9:0]  BL10   = 10'(BURST_LEN);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_BURST,
    RD_REQ,
    RD_BURST
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] wr_ptr_q, wr_ptr_d;
  logic [23:0] rd_ptr_q, rd_ptr_d;
  logic [15:0] fill_q, fill_d;
  logic [15:0] ack_cnt_q, ack_cnt_d;
  logic        full_q, full_d;
  logic        empty_q, empty_d;
  logic        err_q, err_d;
  logic        last_rd_q, last_rd_d;
  logic        clr_pend_q, clr_pend_d;
  logic        wr_req_q, wr_req_d;
  logic        rd_req_q, rd_req_d;

  logic        wr_ok, rd_ok, clr_now;
  logic [23:0] wr_nxt, rd_nxt;
  logic [15:0] ack_inc;

  assign wr_ok = i_init_done & ~full_q &
                 (32'(i_wr_fifo_cnt) >= BURST_LEN);
  assign rd_ok = i_init_done & i_rd_enable & ~empty_q &
                 (32'(i_rd_fifo_cnt) + BURST_LEN <= FIFO_DEPTH);

  assign wr_nxt = (wr_ptr_q + BL24 == END_ADDR) ?
                  BASE_ADDR : wr_ptr_q + BL24;
  assign rd_nxt = (rd_ptr_q + BL24 == END_ADDR) ?
                  BASE_ADDR : rd_ptr_q + BL24;

  assign ack_inc = (ack_cnt_q == 16'hFFFF) ?
                   ack_cnt_q : ack_cnt_q + 16'd1;
  assign clr_now = clr_pend_q | i_clear;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    ack_cnt_d  = ack_cnt_q;
    err_d      = err_q;
    last_rd_d  = last_rd_q;
    clr_pend_d = clr_pend_q;
    wr_req_d   = wr_req_q;
    rd_req_d   = rd_req_q;

    if (state_q != IDLE && i_clear)
      clr_pend_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        // a clear cycle never grants: fill is stale until it lands
        if (i_clear) begin
          wr_ptr_d = BASE_ADDR;
          rd_ptr_d = BASE_ADDR;
          fill_d   = '0;
        end else if (wr_ok && (!rd_ok || last_rd_q)) begin
          state_d   = WR_REQ;
          wr_req_d  = 1'b1;
          last_rd_d = 1'b0;
        end else if (rd_ok) begin
          state_d   = RD_REQ;
          rd_req_d  = 1'b1;
          last_rd_d = 1'b1;
        end
      end
      WR_REQ: begin
        if (i_wr_ack) begin
          wr_req_d  = 1'b0;
          ack_cnt_d = 16'd1;
          state_d   = WR_BURST;
        end
      end
      WR_BURST: begin
        if (i_wr_ack) begin
          ack_cnt_d = ack_inc;
        end else begin
          state_d    = IDLE;
          clr_pend_d = 1'b0;
          if (ack_cnt_q != BL16)
            err_d = 1'b1;
          if (clr_now) begin
            wr_ptr_d = BASE_ADDR;
            rd_ptr_d = BASE_ADDR;
            fill_d   = '0;
          end else begin
            wr_ptr_d = wr_nxt;
            fill_d   = fill_q + 16'd1;
          end
        end
      end
      RD_REQ: begin
        if (i_rd_ack) begin
          rd_req_d  = 1'b0;
          ack_cnt_d = 16'd1;
          state_d   = RD_BURST;
        end
      end
      RD_BURST: begin
        if (i_rd_ack) begin
          ack_cnt_d = ack_inc;
        end else begin
          state_d    = IDLE;
          clr_pend_d = 1'b0;
          if (ack_cnt_q != BL16)
            err_d = 1'b1;
          if (clr_now) begin
            wr_ptr_d = BASE_ADDR;
            rd_ptr_d = BASE_ADDR;
            fill_d   = '0;
          end else begin
            rd_ptr_d = rd_nxt;
            fill_d   = fill_q - 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    full_d  = (fill_d == RING_B);
    empty_d = (fill_d == 16'd0);
  end

  always_ff @(posedge i_sysclk or posedge i_sysrst) begin
    if (i_sysrst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= BASE_ADDR;
      rd_ptr_q   <= BASE_ADDR;
      fill_q     <= '0;
      ack_cnt_q  <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      err_q      <= 1'b0;
      last_rd_q  <= 1'b1;
      clr_pend_q <= 1'b0;
      wr_req_q   <= 1'b0;
      rd_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      ack_cnt_q  <= ack_cnt_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      err_q      <= err_d;
      last_rd_q  <= last_rd_d;
      clr_pend_q <= clr_pend_d;
      wr_req_q   <= wr_req_d;
      rd_req_q   <= rd_req_d;
    end
  end

  assign o_wr_req       = wr_req_q;
  assign o_rd_req       = rd_req_q;
  assign o_wr_addr      = wr_ptr_q;
  assign o_rd_addr      = rd_ptr_q;
  assign o_wr_burst_len = BL10;
  assign o_rd_burst_len = BL10;
  assign o_fill         = fill_q;
  assign o_full         = full_q;
  assign o_empty        = empty_q;
  assign o_err          = err_q;

endmodule

// File: tb/tb_sdram_burst_sched.sv
// Bench for sdram_burst_sched: directed vector table, hand sequences,
// then random traffic against a transaction-level ring model.
module tb_sdram_burst_sched;

  localparam int BL    = 256;
  localparam int RING  = 16;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_init_done, i_clear, i_rd_enable;
  logic [10:0] i_wr_fifo_cnt, i_rd_fifo_cnt;
  logic        o_wr_req, o_rd_req;
  logic [23:0] o_wr_addr, o_rd_addr;
  logic [9:0]  o_wr_burst_len, o_rd_burst_len;
  logic        i_wr_ack, i_rd_ack;
  logic [15:0] o_fill;
  logic        o_full, o_empty, o_err;

  int n_chk = 0;
  int n_fail = 0;

  sdram_burst_sched #(
    .BURST_LEN (256),
    .BASE_ADDR (24'h000000),
    .END_ADDR  (24'h001000),
    .FIFO_DEPTH(1024)
  ) dut (
    .i_sysclk      (clk),
    .i_sysrst      (rst),
    .i_init_done   (i_init_done),
    .i_clear       (i_clear),
    .i_rd_enable   (i_rd_enable),
    .i_wr_fifo_cnt (i_wr_fifo_cnt),
    .i_rd_fifo_cnt (i_rd_fifo_cnt),
    .o_wr_req      (o_wr_req),
    .o_wr_addr     (o_wr_addr),
    .o_wr_burst_len(o_wr_burst_len),
    .i_wr_ack      (i_wr_ack),
    .o_rd_req      (o_rd_req),
    .o_rd_addr     (o_rd_addr),
    .o_rd_burst_len(o_rd_burst_len),
    .i_rd_ack      (i_rd_ack),
    .o_fill        (o_fill),
    .o_full        (o_full),
    .o_empty       (o_empty),
    .o_err         (o_err)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int init; int rd_en; int wrc; int rdc;
    int nacks; int clr_at;
    int side; int addr; int fill;
    int wptr; int rptr; int err;
  } vec_t;

  vec_t tbl[16];

  // transaction-level ring model
  int m_fill, m_w, m_r, m_last_rd, m_err;

  task automatic chk(input string name,
                     input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_init_done   = 1'b0;
    i_clear       = 1'b0;
    i_rd_enable   = 1'b0;
    i_wr_fifo_cnt = '0;
    i_rd_fifo_cnt = '0;
    i_wr_ack      = 1'b0;
    i_rd_ack      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_ring(input string tag, input int fill,
                            input int wptr, input int rptr,
                            input int err);
    chk({tag, "_fill"}, o_fill, fill);
    chk({tag, "_full"}, o_full, fill == RING);
    chk({tag, "_empty"}, o_empty, fill == 0);
    chk({tag, "_wptr"}, o_wr_addr, wptr);
    chk({tag, "_rptr"}, o_rd_addr, rptr);
    chk({tag, "_err"}, o_err, err);
  endtask

  // side: 0 none, 1 write, 2 read (matches {o_rd_req,o_wr_req})
  task automatic run_txn(input int init, input int rd_en,
                         input int wrc, input int rdc,
                         input int nacks, input int clr_at,
                         input int side, input int addr,
                         input int fill, input int wptr,
                         input int rptr, input int err);
    logic [1:0] act;
    bit got;
    i_init_done   = init[0];
    i_rd_enable   = rd_en[0];
    i_wr_fifo_cnt = 11'(wrc);
    i_rd_fifo_cnt = 11'(rdc);
    got = 0;
    act = 2'b00;
    if (side == 0) begin
      repeat (8) begin
        @(negedge clk);
        if (o_wr_req | o_rd_req) got = 1;
      end
      chk("no_req", got, 0);
    end else begin
      for (int c = 0; c < 4 && !got; c++) begin
        @(negedge clk);
        if (o_wr_req | o_rd_req) got = 1;
      end
      chk("req_seen", got, 1);
      if (!got) return;
      act = {o_rd_req, o_wr_req};
      chk("req_side", act, side);
      chk("req_addr", act == 2'b10 ? o_rd_addr : o_wr_addr, addr);
      for (int k = 0; k < nacks; k++) begin
        i_wr_ack = (act != 2'b10);
        i_rd_ack = (act == 2'b10);
        i_clear  = (k == clr_at);
        @(negedge clk);
        if (k == 0)
          chk("req_drop", {o_rd_req, o_wr_req}, 0);
        if (k == nacks / 2)
          chk("addr_hold",
              act == 2'b10 ? o_rd_addr : o_wr_addr, addr);
      end
      i_wr_ack = 1'b0;
      i_rd_ack = 1'b0;
      i_clear  = 1'b0;
      @(negedge clk);
      chk("idle_gap", {o_rd_req, o_wr_req}, 0);
    end
    check_ring("ring", fill, wptr, rptr, err);
  endtask

  task automatic model_reset();
    m_fill = 0; m_w = 0; m_r = 0;
    m_last_rd = 1; m_err = 0;
  endtask

  initial begin
    int wrc, rdc, init, rd_en, nacks, clr_at, side, addr, r;
    bit wok, rok, got;

    tbl[0]  = '{1,0,300,0,256,-1, 1,'h000, 1,'h100,'h000,0};
    tbl[1]  = '{1,0,300,0,256,-1, 1,'h100, 2,'h200,'h000,0};
    tbl[2]  = '{1,0,300,0,256,-1, 1,'h200, 3,'h300,'h000,0};
    tbl[3]  = '{1,1,0,0,256,-1,   2,'h000, 2,'h300,'h100,0};
    tbl[4]  = '{1,1,300,0,256,-1, 1,'h300, 3,'h400,'h100,0};
    tbl[5]  = '{1,1,300,0,256,-1, 2,'h100, 2,'h400,'h200,0};
    tbl[6]  = '{1,1,300,0,256,-1, 1,'h400, 3,'h500,'h200,0};
    tbl[7]  = '{1,1,300,0,256,-1, 2,'h200, 2,'h500,'h300,0};
    tbl[8]  = '{1,1,0,900,256,-1, 0,0,     2,'h500,'h300,0};
    tbl[9]  = '{1,1,0,768,256,-1, 2,'h300, 1,'h500,'h400,0};
    tbl[10] = '{1,0,255,0,256,-1, 0,0,     1,'h500,'h400,0};
    tbl[11] = '{1,0,256,0,256,-1, 1,'h500, 2,'h600,'h400,0};
    tbl[12] = '{1,0,300,0,255,-1, 1,'h600, 3,'h700,'h400,1};
    tbl[13] = '{1,0,300,0,256,-1, 1,'h700, 4,'h800,'h400,1};
    tbl[14] = '{1,0,300,0,256,100,1,'h800, 0,'h000,'h000,1};
    tbl[15] = '{1,1,0,0,256,-1,   0,0,     0,'h000,'h000,1};

    do_reset();
    chk("rst_wr_req", o_wr_req, 0);
    chk("rst_rd_req", o_rd_req, 0);
    check_ring("rst", 0, 0, 0, 0);
    chk("wr_blen", o_wr_burst_len, BL);
    chk("rd_blen", o_rd_burst_len, BL);

    // init gating
    i_wr_fifo_cnt = 11'd300;
    got = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_wr_req | o_rd_req) got = 1;
    end
    chk("init_gate", got, 0);

    foreach (tbl[i])
      run_txn(tbl[i].init, tbl[i].rd_en, tbl[i].wrc, tbl[i].rdc,
              tbl[i].nacks, tbl[i].clr_at, tbl[i].side,
              tbl[i].addr, tbl[i].fill, tbl[i].wptr,
              tbl[i].rptr, tbl[i].err);
    idle_inputs();
    @(negedge clk);
    chk("err_sticky", o_err, 1);

    // reset clears the sticky error; stray acks in IDLE are ignored
    do_reset();
    chk("rst_err", o_err, 0);
    i_wr_ack = 1'b1;
    i_rd_ack = 1'b1;
    repeat (3) @(negedge clk);
    i_wr_ack = 1'b0;
    i_rd_ack = 1'b0;
    @(negedge clk);
    check_ring("idle_ack", 0, 0, 0, 0);

    // fill the ring completely, then the write side must stall
    for (int i = 0; i < RING; i++)
      run_txn(1, 0, 1024, 0, 256, -1, 1, i * BL, i + 1,
              ((i + 1) % RING) * BL, 0, 0);
    run_txn(1, 0, 1024, 0, 256, -1, 0, 0, RING, 0, 0, 0);
    run_txn(1, 1, 0, 0, 256, -1, 2, 0, RING - 1, 0, BL, 0);

    // clear while idle
    idle_inputs();
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
    @(negedge clk);
    check_ring("idle_clr", 0, 0, 0, 0);

    // reset in the middle of a burst
    run_txn(1, 0, 300, 0, 256, -1, 1, 0, 1, BL, 0, 0);
    i_init_done   = 1'b1;
    i_wr_fifo_cnt = 11'd300;
    got = 0;
    for (int c = 0; c < 4 && !got; c++) begin
      @(negedge clk);
      if (o_wr_req) got = 1;
    end
    chk("mid_req", got, 1);
    i_wr_ack = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", {o_rd_req, o_wr_req}, 0);
    check_ring("mid_rst", 0, 0, 0, 0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // random traffic against the model
    do_reset();
    model_reset();
    for (int t = 0; t < 40; t++) begin
      init  = ($urandom_range(0, 9) != 0);
      rd_en = ($urandom_range(0, 3) != 0);
      wrc   = ($urandom_range(0, 3) == 0) ?
              $urandom_range(0, BL - 1) : $urandom_range(BL, 1024);
      rdc   = ($urandom_range(0, 1) == 0) ?
              $urandom_range(0, DEPTH - BL) :
              $urandom_range(DEPTH - BL + 1, 1023);
      r     = $urandom_range(0, 19);
      nacks = (r == 0) ? BL - 1 : (r == 1) ? BL + 1 : BL;
      clr_at = ($urandom_range(0, 14) == 0) ?
               $urandom_range(0, nacks - 1) : -1;

      wok = init != 0 && m_fill < RING && wrc >= BL;
      rok = init != 0 && rd_en != 0 && m_fill > 0 &&
            DEPTH - rdc >= BL;
      side = (wok && rok) ? (m_last_rd ? 1 : 2) :
             wok ? 1 : rok ? 2 : 0;
      addr = (side == 2 ? m_r : m_w) * BL;

      if (side != 0) begin
        m_last_rd = (side == 2);
        if (nacks != BL) m_err = 1;
        if (clr_at >= 0) begin
          m_fill = 0; m_w = 0; m_r = 0;
        end else if (side == 1) begin
          m_w = (m_w + 1) % RING;
          m_fill++;
        end else begin
          m_r = (m_r + 1) % RING;
          m_fill--;
        end
      end
      run_txn(init, rd_en, wrc, rdc, nacks, clr_at, side, addr,
              m_fill, m_w * BL, m_r * BL, m_err);
    end
    idle_inputs();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
